// File: rtl/param_sequence_detector_if.sv
// Bus bundle for the parametrised serial pattern detector.
// The master side drives the bit stream and control strobes; the slave side returns the match status.
interface param_sequence_detector_if #(
  parameter int PATTERN_W = 4,
  parameter int CNT_W     = 8
);
  logic                 en;
  logic                 a;
  logic                 overlap;
  logic                 load;
  logic [PATTERN_W-1:0] pattern_in;
  logic                 clr_count;
  logic                 out;
  logic [CNT_W-1:0]     match_count;

  modport master (
    output en, a, overlap, load, pattern_in, clr_count,
    input  out, match_count
  );

  modport slave (
    input  en, a, overlap, load, pattern_in, clr_count,
    output out, match_count
  );
endinterface

// File: rtl/param_sequence_detector.sv
// Serial pattern detector: shifts qualified bits into a history register, matches a loadable pattern,
// and reports a registered one-cycle pulse plus a saturating match counter.
module param_sequence_detector #(
  parameter int                   PATTERN_W     = 4,
  parameter logic [PATTERN_W-1:0] RESET_PATTERN = 4'b1001,
  parameter int                   CNT_W         = 8
) (
  input logic                      clk,
  input logic                      rst,
  param_sequence_detector_if.slave bus
);

  localparam int                FILL_W    = $clog2(PATTERN_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PATTERN_W);
  localparam logic [FILL_W-1:0] FILL_ARM  = FILL_W'(PATTERN_W - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  logic [PATTERN_W-1:0] patReg_q, patReg_d;
  logic [PATTERN_W-1:0] history_q, history_d;
  logic [PATTERN_W-1:0] nextHist;
  logic [FILL_W-1:0]    fill_q, fill_d;
  logic                 out_q, out_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 match;

  // A match needs a full window of valid bits; the incoming bit supplies the last one.
  always_comb begin
    nextHist = {history_q[PATTERN_W-2:0], bus.a};
    match    = !bus.load && bus.en && (nextHist == patReg_q) && (fill_q >= FILL_ARM);
  end

  always_comb begin
    patReg_d  = patReg_q;
    history_d = history_q;
    fill_d    = fill_q;
    out_d     = 1'b0;
    if (bus.load) begin
      patReg_d = bus.pattern_in;
      fill_d   = '0;
    end else if (bus.en) begin
      history_d = nextHist;
      out_d     = match;
      if (match && !bus.overlap) begin
        fill_d = '0;
      end else if (fill_q != FILL_FULL) begin
        fill_d = fill_q + FILL_W'(1);
      end
    end
  end

  // A clear on the same edge as a match still records that match.
  always_comb begin
    count_d = count_q;
    if (bus.clr_count) begin
      count_d = match ? CNT_W'(1) : '0;
    end else if (match && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      patReg_q  <= RESET_PATTERN;
      history_q <= '0;
      fill_q    <= '0;
      out_q     <= 1'b0;
      count_q   <= '0;
    end else begin
      patReg_q  <= patReg_d;
      history_q <= history_d;
      fill_q    <= fill_d;
      out_q     <= out_d;
      count_q   <= count_d;
    end
  end

  assign bus.out         = out_q;
  assign bus.match_count = count_q;

endmodule

// File: tb/tb_param_sequence_detector.sv
// Randomised and directed bench for param_sequence_detector against a queue-based reference model.
// Two instances run side by side: default counter width and a 2-bit counter for saturation.
module tb_param_sequence_detector;

  logic       clk;
  logic       rst;
  logic       en;
  logic       a;
  logic       overlap;
  logic       load;
  logic [3:0] patternIn;
  logic       clrCount;

  int vectors;
  int miscompares;

  param_sequence_detector_if #(.PATTERN_W(4), .CNT_W(8)) busA ();
  param_sequence_detector_if #(.PATTERN_W(4), .CNT_W(2)) busB ();

  assign busA.en         = en;
  assign busA.a          = a;
  assign busA.overlap    = overlap;
  assign busA.load       = load;
  assign busA.pattern_in = patternIn;
  assign busA.clr_count  = clrCount;
  assign busB.en         = en;
  assign busB.a          = a;
  assign busB.overlap    = overlap;
  assign busB.load       = load;
  assign busB.pattern_in = patternIn;
  assign busB.clr_count  = clrCount;

  param_sequence_detector #(.PATTERN_W(4), .RESET_PATTERN(4'b1001), .CNT_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(busA)
  );

  param_sequence_detector #(.PATTERN_W(4), .RESET_PATTERN(4'b1001), .CNT_W(2)) dutSat (
    .clk(clk),
    .rst(rst),
    .bus(busB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the bits accepted since the last restart, kept as a queue of at most 4.
  logic [3:0] mPat;
  bit         mValid[$];
  bit         mOut;
  int         mCnt8;
  int         mCnt2;

  task automatic modelReset();
    mPat = 4'b1001;
    mValid.delete();
    mOut  = 1'b0;
    mCnt8 = 0;
    mCnt2 = 0;
  endtask

  task automatic modelEdge();
    bit m;
    int v;
    m = 1'b0;
    if (load) begin
      mPat = patternIn;
      mValid.delete();
    end else if (en) begin
      mValid.push_back(a);
      if (mValid.size() >= 4) begin
        v = 0;
        for (int i = mValid.size() - 4; i < mValid.size(); i++) v = (v << 1) | int'(mValid[i]);
        m = (v == int'(mPat));
      end
      if (m && !overlap) mValid.delete();
      while (mValid.size() > 4) void'(mValid.pop_front());
    end
    mOut = m;
    if (clrCount) begin
      mCnt8 = m ? 1 : 0;
      mCnt2 = m ? 1 : 0;
    end else if (m) begin
      if (mCnt8 < 255) mCnt8++;
      if (mCnt2 < 3) mCnt2++;
    end
  endtask

  // Drives one clock worth of inputs, waits past the edge, and advances the model.
  task automatic applyStimulus(input bit e, input bit bitA, input bit ov, input bit ld,
                               input logic [3:0] pat, input bit clr);
    en        = e;
    a         = bitA;
    overlap   = ov;
    load      = ld;
    patternIn = pat;
    clrCount  = clr;
    @(posedge clk);
    #1;
    modelEdge();
  endtask

  // Asynchronous reset pulse placed mid-cycle, away from any edge.
  task automatic pulseReset();
    #2;
    rst = 1'b0;
    #2;
    rst = 1'b1;
    modelReset();
  endtask

  task automatic test_reset();
    en = 1'b1; a = 1'b1; overlap = 1'b1; load = 1'b0; patternIn = 4'b0000; clrCount = 1'b0;
    rst = 1'b0;
    modelReset();
    #2;
    vectors++;
    if (busA.out !== 1'b0 || busA.match_count !== 8'd0 || busB.match_count !== 2'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_state: out=%b cnt8=%0d cnt2=%0d, want 0/0/0", busA.out, busA.match_count, busB.match_count);
    end
    repeat (6) begin
      @(posedge clk);
      a = ~a;
    end
    #1;
    vectors++;
    if (busA.out !== 1'b0 || busA.match_count !== 8'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_hold: out=%b cnt8=%0d, want 0/0", busA.out, busA.match_count);
    end
    #2;
    rst = 1'b1;
  endtask

  task automatic test_overlap();
    bit s[7] = '{1, 0, 0, 1, 0, 0, 1};
    bit p[7] = '{0, 0, 0, 1, 0, 0, 1};
    pulseReset();
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b1, s[i], 1'b1, 1'b0, 4'b0000, 1'b0);
      vectors++;
      if (busA.out !== p[i]) begin
        miscompares++;
        $display("[TB] FAIL overlap_out bit%0d: got %b want %b", i + 1, busA.out, p[i]);
      end
    end
    vectors++;
    if (busA.match_count !== 8'd2) begin
      miscompares++;
      $display("[TB] FAIL overlap_count: got %0d want 2", busA.match_count);
    end
  endtask

  task automatic test_non_overlap();
    bit s[7] = '{1, 0, 0, 1, 0, 0, 1};
    bit p[7] = '{0, 0, 0, 1, 0, 0, 0};
    pulseReset();
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b1, s[i], 1'b0, 1'b0, 4'b0000, 1'b0);
      vectors++;
      if (busA.out !== p[i]) begin
        miscompares++;
        $display("[TB] FAIL nonovl_out bit%0d: got %b want %b", i + 1, busA.out, p[i]);
      end
    end
    vectors++;
    if (busA.match_count !== 8'd1) begin
      miscompares++;
      $display("[TB] FAIL nonovl_count: got %0d want 1", busA.match_count);
    end
  endtask

  task automatic test_load();
    bit s[6] = '{0, 1, 0, 1, 0, 1};
    bit p[6] = '{0, 0, 0, 1, 0, 1};
    bit t[4] = '{1, 0, 0, 1};
    pulseReset();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 4'b0101, 1'b0);
    vectors++;
    if (busA.out !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL load_out: got %b want 0", busA.out);
    end
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, s[i], 1'b1, 1'b0, 4'b0000, 1'b0);
      vectors++;
      if (busA.out !== p[i]) begin
        miscompares++;
        $display("[TB] FAIL load_new_pat bit%0d: got %b want %b", i + 1, busA.out, p[i]);
      end
    end
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 4'b0101, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, t[i], 1'b1, 1'b0, 4'b0000, 1'b0);
      vectors++;
      if (busA.out !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL load_old_pat bit%0d: got %b want 0", i + 1, busA.out);
      end
    end
    vectors++;
    if (busA.match_count !== 8'd2) begin
      miscompares++;
      $display("[TB] FAIL load_count: got %0d want 2", busA.match_count);
    end
  endtask

  task automatic test_saturation();
    int expCnt[5] = '{1, 2, 3, 3, 3};
    int k;
    pulseReset();
    k = 0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, (i == 0) || (i % 3 == 0), 1'b1, 1'b0, 4'b0000, 1'b0);
      if (i % 3 == 0 && i > 0) begin
        vectors++;
        if (busB.match_count !== 2'(expCnt[k]) || busB.out !== 1'b1) begin
          miscompares++;
          $display("[TB] FAIL sat_count match%0d: got cnt=%0d out=%b want cnt=%0d out=1",
                   k + 1, busB.match_count, busB.out, expCnt[k]);
        end
        k++;
      end
    end
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b1);
    vectors++;
    if (busB.match_count !== 2'd1 || busA.match_count !== 8'd1 || busA.out !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL clr_with_match: cnt2=%0d cnt8=%0d out=%b want 1/1/1",
               busB.match_count, busA.match_count, busA.out);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b1);
    vectors++;
    if (busA.match_count !== 8'd0) begin
      miscompares++;
      $display("[TB] FAIL clr_alone: got %0d want 0", busA.match_count);
    end
  endtask

  task automatic test_en_gating();
    pulseReset();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
      vectors++;
      if (busA.out !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL en_gap cycle%0d: got %b want 0", i, busA.out);
      end
    end
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
    vectors++;
    if (busA.out !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL en_early: got %b want 0", busA.out);
    end
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
    vectors++;
    if (busA.out !== 1'b1 || busA.match_count !== 8'd1) begin
      miscompares++;
      $display("[TB] FAIL en_pulse: out=%b cnt=%0d want 1/1", busA.out, busA.match_count);
    end
  endtask

  task automatic test_async_reset();
    bit s[5] = '{1, 1, 0, 0, 1};
    bit p[5] = '{0, 0, 0, 0, 1};
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
    #3;
    rst = 1'b0;
    modelReset();
    #1;
    vectors++;
    if (busA.out !== 1'b0 || busA.match_count !== 8'd0 || busB.match_count !== 2'd0) begin
      miscompares++;
      $display("[TB] FAIL async_reset: out=%b cnt8=%0d cnt2=%0d want 0/0/0",
               busA.out, busA.match_count, busB.match_count);
    end
    @(posedge clk);
    #2;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, s[i], 1'b1, 1'b0, 4'b0000, 1'b0);
      vectors++;
      if (busA.out !== p[i]) begin
        miscompares++;
        $display("[TB] FAIL post_reset bit%0d: got %b want %b", i + 1, busA.out, p[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] pat;
    bit         ov;
    ov = 1'b1;
    pulseReset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(7) == 0) ov = ~ov;
      pat = 4'($urandom);
      applyStimulus($urandom_range(3) != 0, 1'($urandom), ov, $urandom_range(24) == 0, pat,
                    $urandom_range(30) == 0);
      vectors++;
      if (busA.out !== mOut || busB.out !== mOut || busA.match_count !== 8'(mCnt8)
          || busB.match_count !== 2'(mCnt2)) begin
        miscompares++;
        $display("[TB] FAIL random cycle%0d: out=%b/%b cnt8=%0d cnt2=%0d want out=%b cnt8=%0d cnt2=%0d",
                 i, busA.out, busB.out, busA.match_count, busB.match_count, mOut, mCnt8, mCnt2);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_overlap();
    test_non_overlap();
    test_load();
    test_saturation();
    test_en_gating();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/param_sequence_detector.md
Name: param_sequence_detector

Overview:
- Parametrised serial pattern detector, generalising the fixed single-pattern detector.
- Shifts a 1-bit input stream into a history register and compares it against a runtime-loadable PATTERN_W-bit pattern.
- Selectable overlapping or non-overlapping detection.
- Outputs a registered one-cycle match pulse plus a saturating match counter for status/debug readout.

Parameters:
- PATTERN_W, 4, pattern length in bits; legal range 2..32.
- RESET_PATTERN, 4'b1001, pattern loaded at reset; PATTERN_W bits wide.
- CNT_W, 8, match counter width; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  bit-valid qualifier; `a` is sampled only when high.
- a  input  1  serial data bit.
- overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
- load  input  1  pattern load strobe.
- pattern_in  input  PATTERN_W  new pattern, captured when load=1.
- clr_count  input  1  synchronous clear of match_count.
- out  output  1  registered match pulse.
- match_count  output  CNT_W  saturating count of matches.

Behaviour:
- Reset (rst=0, asynchronous, no clock needed):
  - pat_reg=RESET_PATTERN, history=0, fill=0, out=0, match_count=0.
  - All registers remain held while rst=0.
- State:
  - pat_reg[PATTERN_W-1:0].
  - history[PATTERN_W-1:0]: newest bit at LSB; the oldest bit aligns with pat_reg MSB.
  - fill: saturating count of valid bits in history, 0..PATTERN_W, width clog2(PATTERN_W+1).
- Per rising edge, priority order load > en:
  - load=1:
    - pat_reg<=pattern_in, fill<=0, out<=0.
    - history is unchanged; `a` is ignored that cycle.
  - load=0, en=1:
    - next_hist={history[PATTERN_W-2:0],a}.
    - match = (next_hist==pat_reg) && (fill>=PATTERN_W-1).
    - history<=next_hist.
    - out<=match.
    - If match and overlap=0: fill<=0. Otherwise fill<=min(fill+1,PATTERN_W).
  - load=0, en=0: history and fill are held; out<=0.
- Latency:
  - out is high for exactly the one cycle after the edge that sampled the final pattern bit.
  - No combinational path from a to out.
- Overlap mode takes effect on the edge it is sampled; no pipeline state is flushed on a mode change.
- match_count, evaluated each edge:
  - clr_count=1 and match=1: count<=1.
  - clr_count=1 and match=0: count<=0.
  - match=1 otherwise: count<=count+1, saturating at 2^CNT_W-1 with no wrap.
  - A load on the same edge forces match=0.
- The pattern changes only via load or reset; the counter is unaffected by load.
- Reset mid-stream discards the partial sequence. The first match after reset requires PATTERN_W fresh bits.

Test Plan:
- Defaults (PATTERN_W=4, pattern 1001), overlap=1, en=1, stream 1,0,0,1,0,0,1 -> out pulses after the 4th and 7th bits; match_count=2.
- Same stream, overlap=0 -> single pulse after the 4th bit; match_count=1 (bits 5-7 give fill=3 only).
- load with pattern_in=4'b0101, then overlap=1, stream 0,1,0,1,0,1 -> pulses after the 4th and 6th bits. Separately, a 1,0,0,1 stream after this load -> no pulse.
- CNT_W=2, 5 overlapping matches -> match_count reads 1,2,3,3,3. Then clr_count on the same edge as a 6th match -> match_count=1.
- en gating: stream 1,0, then en=0 for 3 cycles with a=1, then 0,1 -> out=0 during the gap; pulse after the final 1.
- Stream 1,0,0, then rst low mid-cycle -> out=0 and match_count=0 immediately. After release, bit 1 -> no pulse; 1,0,0,1 -> pulse on the 4th bit.
